sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single-outstanding SRAM controller.
// Port 0 is instruction fetch and port 1 is the LSU; a stuck transaction is aborted after TIMEOUT wait cycles.
module sram_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_p0_req,
  input  logic        i_p1_req,
  input  logic        i_p0_wren,
  input  logic        i_p1_wren,
  input  logic [17:0] i_p0_addr,
  input  logic [17:0] i_p1_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p0_bmask,
  input  logic [3:0]  i_p1_bmask,
  output logic        o_p0_ack,
  output logic        o_p1_ack,
  output logic        o_p0_err,
  output logic        o_p1_err,
  output logic [31:0] o_p0_rdata,
  output logic [31:0] o_p1_rdata,
  output logic [17:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  output logic        o_mem_rden,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_ack,
  output logic        o_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  state_t      state;
  state_t      state_next;
  logic        grant;
  logic        last;
  logic        pick;
  logic        wren;
  logic        start;
  logic        finish;
  logic        timeout_hit;
  logic [9:0]  count;
  logic [9:0]  count_inc;

  assign count_inc = count + 10'd1;
  assign o_busy    = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // On a tie the port not served last wins; otherwise the lone requester wins.
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    finish      = 1'b0;
    timeout_hit = 1'b0;
    pick        = (i_p0_req && i_p1_req) ? ~last : i_p1_req;
    case (state)
      IDLE: begin
        if (i_p0_req || i_p1_req) begin
          start      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ack) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_ack) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (count_inc == TIMEOUT_CNT) begin
          finish      = 1'b1;
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once at grant and held until the next grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      grant       <= 1'b0;
      last        <= 1'b1;
      wren        <= 1'b0;
      count       <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_mem_bmask <= '0;
      o_mem_wren  <= 1'b0;
      o_mem_rden  <= 1'b0;
      o_p0_ack    <= 1'b0;
      o_p1_ack    <= 1'b0;
      o_p0_err    <= 1'b0;
      o_p1_err    <= 1'b0;
      o_p0_rdata  <= '0;
      o_p1_rdata  <= '0;
    end else begin
      o_mem_wren <= 1'b0;
      o_mem_rden <= 1'b0;
      o_p0_ack   <= 1'b0;
      o_p1_ack   <= 1'b0;
      o_p0_err   <= 1'b0;
      o_p1_err   <= 1'b0;

      if (start) begin
        grant       <= pick;
        wren        <= pick ? i_p1_wren : i_p0_wren;
        o_mem_addr  <= pick ? i_p1_addr : i_p0_addr;
        o_mem_wdata <= pick ? i_p1_wdata : i_p0_wdata;
        o_mem_bmask <= pick ? i_p1_bmask : i_p0_bmask;
        o_mem_wren  <= pick ? i_p1_wren : i_p0_wren;
        o_mem_rden  <= pick ? ~i_p1_wren : ~i_p0_wren;
      end

      if (state == ISSUE)     count <= '0;
      else if (state == WAIT) count <= count_inc;

      // Writes and aborted transactions both return zero read data.
      if (finish) begin
        if (grant) begin
          o_p1_ack   <= 1'b1;
          o_p1_err   <= timeout_hit;
          o_p1_rdata <= (timeout_hit || wren) ? 32'h0 : i_mem_rdata;
        end else begin
          o_p0_ack   <= 1'b1;
          o_p0_err   <= timeout_hit;
          o_p0_rdata <= (timeout_hit || wren) ? 32'h0 : i_mem_rdata;
        end
      end

      if (state == DONE) last <= grant;
    end
  end

endmodule
